shift_issue_stage: RTL and testbench

Registered issue stage directly upstream of the right-shift cascade (stages 1/2/4/8/16). Accepts ALU shift requests over a valid/ready handshake and converts SLL/SRL/SRA into right-shift form: bit-reversed operand for SLL, fill bit, and per-stage enables. Holds up to two requests in a skid buffer, so the cascade consumer can stall without dropping work.

---
 rtl/shift_pkg.sv | 41 ++++
 rtl/shift_operand_xform.sv | 63 ++++++
 rtl/shift_issue_stage.sv | 168 ++++++++++++++++
 tb/tb_shift_issue_stage.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// -----------------------------------------------------------------------------
// shift_pkg
//   Shared types and constants for the shift issue stage and its operand
//   transform.
//
//   DATA_W      operand width fed to the right-shift cascade (32)
//   SHAMT_W     shift amount width; one enable bit per cascade stage (5)
//   REQ_TAG_W   tag width held in shift_req_t; the issue stage TAG_W
//               parameter is expected to equal this
//   shift_op_t  ALU shift encodings (SLL/SRL/SRA/RSVD)
//   skid_state_t occupancy of the two-entry skid buffer
//   shift_req_t one transformed request as stored in main/skid registers
// -----------------------------------------------------------------------------
package shift_pkg;

  localparam int DATA_W    = 32;
  localparam int SHAMT_W   = 5;
  localparam int REQ_TAG_W = 4;

  typedef enum logic [1:0] {
    SLL  = 2'b00,
    SRL  = 2'b01,
    SRA  = 2'b10,
    RSVD = 2'b11
  } shift_op_t;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b10
  } skid_state_t;

  typedef struct packed {
    logic [DATA_W-1:0]    sh_in;
    logic [SHAMT_W-1:0]   sh_en;
    logic                 sh_fill;
    logic                 sh_rev;
    logic [REQ_TAG_W-1:0] tag;
  } shift_req_t;

endpackage

// File: rtl/shift_operand_xform.sv
// -----------------------------------------------------------------------------
// shift_operand_xform
//   Purely combinational mapping of an ALU shift request onto the inputs of a
//   right-only shift cascade. A left shift is performed as a right shift of
//   the bit-reversed operand; the result is reversed back downstream, which
//   is signalled by sh_rev.
//
//   Ports:
//     a        in   DATA_W   operand
//     shamt    in   SHAMT_W  shift amount
//     op       in   2        shift_op_t encoding
//     sh_in    out  DATA_W   operand for the first cascade stage
//     sh_en    out  SHAMT_W  per-stage enables (equal to shamt)
//     sh_fill  out  1        bit shifted in at the top of every stage
//     sh_rev   out  1        result needs bit reversal (SLL)
//
//   The reserved encoding is mapped like SRL; the issue stage decides whether
//   such a request is enqueued at all.
// -----------------------------------------------------------------------------
module shift_operand_xform
  import shift_pkg::*;
(
  input  logic [DATA_W-1:0]  a,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [1:0]         op,
  output logic [DATA_W-1:0]  sh_in,
  output logic [SHAMT_W-1:0] sh_en,
  output logic               sh_fill,
  output logic               sh_rev
);

  shift_op_t         op_e;
  logic [DATA_W-1:0] a_rev;

  assign op_e = shift_op_t'(op);

  always_comb begin
    a_rev = '0;
    for (int i = 0; i < DATA_W; i++) begin
      a_rev[i] = a[DATA_W-1-i];
    end
  end

  always_comb begin
    sh_in   = a;
    sh_en   = shamt;
    sh_fill = 1'b0;
    sh_rev  = 1'b0;
    case (op_e)
      SLL: begin
        sh_in  = a_rev;
        sh_rev = 1'b1;
      end
      SRA: begin
        sh_fill = a[DATA_W-1];
      end
      default: begin
        // SRL and RSVD: operand passes unchanged with zero fill.
      end
    endcase
  end

endmodule

// File: rtl/shift_issue_stage.sv
// -----------------------------------------------------------------------------
// shift_issue_stage
//   Registered issue stage in front of the 1/2/4/8/16 right-shift cascade.
//   Requests arrive over valid/ready, are transformed on capture into
//   right-shift form, and are held in a two-entry skid buffer (main + skid)
//   so the cascade can stall without loss. Ordering is strictly FIFO.
//
//   Handshake rule (both sides): a transfer happens at a rising clk edge
//   where valid && ready are both high; valid never depends on ready, and
//   in_ready is decoded from the state register alone, so there is no
//   combinational path from out_ready to in_ready.
//
//   Parameters:
//     TAG_W   opaque tag width (must equal shift_pkg::REQ_TAG_W)
//     DATA_W  operand width, fixed at 32
//
//   Ports:
//     clk, rst        clock, synchronous active-high reset
//     in_valid/ready  request handshake
//     in_a, in_shamt, in_op, in_tag   request payload
//     out_valid/ready cascade-side handshake
//     sh_in, sh_en, sh_fill, sh_rev, out_tag   presented request
//     dbg_state       current skid_state_t encoding for observation
//     err_illegal_op  sticky reserved-op flag (only with the macro below)
//
//   Build option: define SHIFT_ISSUE_ILLEGAL_OP_EN to drop in_op = 11
//   requests on accept and raise err_illegal_op. Without it, in_op = 11 is
//   handled as SRL and enqueued normally.
// -----------------------------------------------------------------------------
module shift_issue_stage
  import shift_pkg::*;
#(
  parameter int TAG_W  = 4,
  parameter int DATA_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [4:0]       in_shamt,
  input  logic [1:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DATA_W-1:0] sh_in,
  output logic [4:0]       sh_en,
  output logic             sh_fill,
  output logic             sh_rev,
  output logic [TAG_W-1:0] out_tag,
`ifdef SHIFT_ISSUE_ILLEGAL_OP_EN
  output logic             err_illegal_op,
`endif
  output logic [1:0]       dbg_state
);

  skid_state_t state_q, state_d;
  shift_req_t  main_q, main_d;
  shift_req_t  skid_q, skid_d;
  shift_req_t  in_req;

  logic                 accept;
  logic                 enq;
  logic [DATA_W-1:0]    x_sh_in;
  logic [SHAMT_W-1:0]   x_sh_en;
  logic                 x_sh_fill;
  logic                 x_sh_rev;

  // Occupancy-only decode keeps both handshake outputs purely registered.
  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign accept    = in_valid && in_ready;

`ifdef SHIFT_ISSUE_ILLEGAL_OP_EN
  logic err_q;
  // A reserved-op request completes its handshake but never occupies a slot.
  assign enq = accept && (in_op != RSVD);
`else
  assign enq = accept;
`endif

  shift_operand_xform u_xform (
    .a       (in_a),
    .shamt   (in_shamt),
    .op      (in_op),
    .sh_in   (x_sh_in),
    .sh_en   (x_sh_en),
    .sh_fill (x_sh_fill),
    .sh_rev  (x_sh_rev)
  );

  always_comb begin
    in_req         = '0;
    in_req.sh_in   = x_sh_in;
    in_req.sh_en   = x_sh_en;
    in_req.sh_fill = x_sh_fill;
    in_req.sh_rev  = x_sh_rev;
    in_req.tag     = REQ_TAG_W'(in_tag);
  end

  // Next-state and register-load decisions. The main register always holds
  // the oldest request; the skid register only fills when a new request
  // arrives while the main entry is stalled.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (enq) begin
          state_d = ONE;
          main_d  = in_req;
        end
      end
      ONE: begin
        if (enq && out_ready) begin
          main_d = in_req;
        end else if (enq) begin
          state_d = FULL;
          skid_d  = in_req;
        end else if (out_ready) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_ready) begin
          state_d = ONE;
          main_d  = skid_q;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

`ifdef SHIFT_ISSUE_ILLEGAL_OP_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (accept && (in_op == RSVD)) begin
      err_q <= 1'b1;
    end
  end

  assign err_illegal_op = err_q;
`endif

  assign sh_in     = main_q.sh_in;
  assign sh_en     = main_q.sh_en;
  assign sh_fill   = main_q.sh_fill;
  assign sh_rev    = main_q.sh_rev;
  assign out_tag   = TAG_W'(main_q.tag);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_shift_issue_stage.sv
// -----------------------------------------------------------------------------
// tb_shift_issue_stage
//   Directed plus randomized bench for shift_issue_stage. The reference model
//   is a bounded queue of expected presented bundles; the head of the queue is
//   what the stage must present, and it can hold at most two entries.
//   Honors SHIFT_ISSUE_ILLEGAL_OP_EN when compiled with it.
// -----------------------------------------------------------------------------
module tb_shift_issue_stage;

  localparam int TAG_W = 4;
  localparam int EW    = 32 + 5 + 1 + 1 + TAG_W;
`ifdef SHIFT_ISSUE_ILLEGAL_OP_EN
  localparam bit ILLEGAL_EN = 1'b1;
`else
  localparam bit ILLEGAL_EN = 1'b0;
`endif

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_a;
  logic [4:0]       in_shamt;
  logic [1:0]       in_op;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      sh_in;
  logic [4:0]       sh_en;
  logic             sh_fill;
  logic             sh_rev;
  logic [TAG_W-1:0] out_tag;
  logic [1:0]       dbg_state;
`ifdef SHIFT_ISSUE_ILLEGAL_OP_EN
  logic             err_illegal_op;
`endif

  shift_issue_stage #(.TAG_W(TAG_W), .DATA_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_shamt  (in_shamt),
    .in_op     (in_op),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sh_in     (sh_in),
    .sh_en     (sh_en),
    .sh_fill   (sh_fill),
    .sh_rev    (sh_rev),
    .out_tag   (out_tag),
`ifdef SHIFT_ISSUE_ILLEGAL_OP_EN
    .err_illegal_op (err_illegal_op),
`endif
    .dbg_state (dbg_state)
  );

  // ---------------------------------------------------------------- scoreboard
  int checks   = 0;
  int failures = 0;
  int obs_fires = 0;
  logic [EW-1:0]    exp_q[$];
  logic [TAG_W-1:0] got_q[$];
  logic             err_exp = 1'b0;

  // What the cascade should see for a request, straight from the op rules.
  function automatic logic [EW-1:0] ref_xform(logic [31:0] a, logic [4:0] s,
                                              logic [1:0] op, logic [TAG_W-1:0] t);
    logic [31:0] r;
    logic        fill;
    logic        rev;
    r    = a;
    fill = 1'b0;
    rev  = 1'b0;
    if (op == 2'b00) begin
      r   = {<<{a}};
      rev = 1'b1;
    end else if (op == 2'b10) begin
      fill = a[31];
    end
    return {r, s, fill, rev, t};
  endfunction

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------- driver
  task automatic drive(input logic v, input logic [31:0] a, input logic [4:0] s,
                       input logic [1:0] op, input logic [TAG_W-1:0] t);
    in_valid = v;
    in_a     = a;
    in_shamt = s;
    in_op    = op;
    in_tag   = t;
  endtask

  // Compare against the model, advance one edge, update the model.
  task automatic cycle();
    logic acc;
    chk("in_ready", 64'(in_ready), 64'(exp_q.size() < 2));
    chk("out_valid", 64'(out_valid), 64'(exp_q.size() > 0));
    if (exp_q.size() > 0)
      chk("out_bundle", 64'({sh_in, sh_en, sh_fill, sh_rev, out_tag}), 64'(exp_q[0]));
`ifdef SHIFT_ISSUE_ILLEGAL_OP_EN
    chk("err_illegal_op", 64'(err_illegal_op), 64'(err_exp));
`endif
    if (out_valid && out_ready) begin
      obs_fires++;
      got_q.push_back(out_tag);
    end
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      err_exp = 1'b0;
    end else begin
      acc = in_valid && (exp_q.size() < 2);
      if (exp_q.size() > 0 && out_ready) void'(exp_q.pop_front());
      if (acc) begin
        if (ILLEGAL_EN && in_op == 2'b11) err_exp = 1'b1;
        else exp_q.push_back(ref_xform(in_a, in_shamt, in_op, in_tag));
      end
    end
    #1;
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    rst = 1'b1;
    out_ready = 1'b0;
    drive(1'b0, 32'h0, 5'h0, 2'b00, '0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_sh_in", 64'(sh_in), 64'd0);
    chk("rst_sh_en", 64'(sh_en), 64'd0);
    chk("rst_fill_rev", 64'({sh_fill, sh_rev}), 64'd0);
    chk("rst_tag", 64'(out_tag), 64'd0);
    cycle();
    cycle();

    // SRA with sign fill
    out_ready = 1'b1;
    drive(1'b1, 32'h8000_00F0, 5'd12, 2'b10, 4'd7);
    cycle();
    drive(1'b0, 32'h0, 5'h0, 2'b00, '0);
    chk("sra_valid", 64'(out_valid), 64'd1);
    chk("sra_sh_in", 64'(sh_in), 64'h8000_00F0);
    chk("sra_sh_en", 64'(sh_en), 64'h0C);
    chk("sra_fill", 64'(sh_fill), 64'd1);
    chk("sra_rev", 64'(sh_rev), 64'd0);
    cycle();

    // SLL via bit reversal
    drive(1'b1, 32'h0000_0001, 5'd3, 2'b00, 4'd9);
    cycle();
    drive(1'b0, 32'h0, 5'h0, 2'b00, '0);
    chk("sll_sh_in", 64'(sh_in), 64'h8000_0000);
    chk("sll_sh_en", 64'(sh_en), 64'h03);
    chk("sll_fill", 64'(sh_fill), 64'd0);
    chk("sll_rev", 64'(sh_rev), 64'd1);
    cycle();

    // shamt = 0 passes through with no enables
    drive(1'b1, 32'hDEAD_BEEF, 5'd0, 2'b01, 4'd4);
    cycle();
    drive(1'b0, 32'h0, 5'h0, 2'b00, '0);
    chk("shamt0_valid", 64'(out_valid), 64'd1);
    chk("shamt0_sh_en", 64'(sh_en), 64'd0);
    cycle();

    // Backpressure: tags 1,2,3 with the cascade stalled
    got_q.delete();
    out_ready = 1'b0;
    drive(1'b1, 32'h1111_0001, 5'd1, 2'b01, 4'd1);
    cycle();
    drive(1'b1, 32'h2222_0002, 5'd2, 2'b01, 4'd2);
    cycle();
    drive(1'b1, 32'h3333_0003, 5'd3, 2'b01, 4'd3);
    chk("bp_in_ready_low", 64'(in_ready), 64'd0);
    chk("bp_head_tag", 64'(out_tag), 64'd1);
    cycle();
    chk("bp_hold_tag", 64'(out_tag), 64'd1);
    chk("bp_hold_sh_in", 64'(sh_in), 64'h1111_0001);
    cycle();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (in_valid && in_ready) begin
        cycle();
        drive(1'b0, 32'h0, 5'h0, 2'b00, '0);
      end else begin
        cycle();
      end
    end
    chk("bp_order_count", 64'(got_q.size()), 64'd3);
    if (got_q.size() == 3) begin
      chk("bp_order_0", 64'(got_q[0]), 64'd1);
      chk("bp_order_1", 64'(got_q[1]), 64'd2);
      chk("bp_order_2", 64'(got_q[2]), 64'd3);
    end

    // Streaming: ten back-to-back requests, never fills
    obs_fires = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, $urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 2)), TAG_W'(i));
      chk("stream_in_ready", 64'(in_ready), 64'd1);
      cycle();
    end
    drive(1'b0, 32'h0, 5'h0, 2'b00, '0);
    cycle();
    chk("stream_transfers", 64'(obs_fires), 64'd10);
    chk("stream_drained", 64'(out_valid), 64'd0);

    // Reset while FULL, with a handshake offered during reset
    out_ready = 1'b0;
    drive(1'b1, 32'hAAAA_0001, 5'd5, 2'b01, 4'd1);
    cycle();
    drive(1'b1, 32'hAAAA_0002, 5'd6, 2'b01, 4'd2);
    cycle();
    chk("full_in_ready", 64'(in_ready), 64'd0);
    rst = 1'b1;
    out_ready = 1'b1;
    cycle();
    rst = 1'b0;
    drive(1'b0, 32'h0, 5'h0, 2'b00, '0);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    cycle();

    // Reserved op
    drive(1'b1, 32'h1234_5678, 5'd4, 2'b11, 4'd5);
    cycle();
    drive(1'b0, 32'h0, 5'h0, 2'b00, '0);
`ifdef SHIFT_ISSUE_ILLEGAL_OP_EN
    chk("rsvd_out_valid", 64'(out_valid), 64'd0);
    chk("rsvd_err", 64'(err_illegal_op), 64'd1);
`else
    chk("rsvd_out_valid", 64'(out_valid), 64'd1);
    chk("rsvd_sh_in", 64'(sh_in), 64'h1234_5678);
    chk("rsvd_fill_rev", 64'({sh_fill, sh_rev}), 64'd0);
`endif
    cycle();

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), $urandom, 5'($urandom_range(0, 31)),
            2'($urandom_range(0, 3)), TAG_W'($urandom_range(0, 15)));
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    drive(1'b0, 32'h0, 5'h0, 2'b00, '0);
    out_ready = 1'b1;
    repeat (3) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
